// File: rtl/iris_axil_master_pkg.sv
// Shared iris AXI-Lite definitions: response codes, default widths and the
// initiator FSM state encoding.
package iris_axil_master_pkg;

   localparam int DATA_W_DEF = 24;
   localparam int ADDR_W_DEF = 16;
   localparam int STRB_W     = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

endpackage

// File: rtl/iris_axil_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AW/W/B or AR/R exchange, one response out.
// Latency: rsp_valid 4 cycles after command accept with a zero-wait responder.
// Backpressure: cmd_ready only in IDLE; waits indefinitely on AXI readies/valids and rsp_ready.
module iris_axil_master
   import iris_axil_master_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int ADDR_WIDTH = ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_W-1:0]     cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  axi_awvalid,
   output logic [ADDR_WIDTH-1:0] axi_awaddr,
   input  logic                  axi_awready,
   output logic                  axi_wvalid,
   output logic [DATA_WIDTH-1:0] axi_wdata,
   output logic [STRB_W-1:0]     axi_wstrb,
   output logic                  axi_wlast,
   input  logic                  axi_wready,
   input  logic                  axi_bvalid,
   input  logic [1:0]            axi_bresp,
   output logic                  axi_bready,
   output logic                  axi_arvalid,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   input  logic                  axi_arready,
   input  logic                  axi_rvalid,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rlast,
   output logic                  axi_rready
);

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic                    r_cmd_ready;
   logic                    r_awvalid;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic                    r_wvalid;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]       r_wstrb;
   logic                    r_wlast;
   logic                    r_aw_done;
   logic                    r_w_done;
   logic                    r_bready;
   logic                    r_arvalid;
   logic [ADDR_WIDTH-1:0]   r_araddr;
   logic                    r_rready;
   logic                    r_rsp_valid;
   logic                    r_rsp_write;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]              r_rsp_resp;

   logic                    w_cmd_fire;
   logic                    w_aw_fire;
   logic                    w_w_fire;
   logic                    w_wr_done;
   logic                    w_b_fire;
   logic                    w_ar_fire;
   logic                    w_r_fire;
   logic                    w_rsp_fire;
   logic                    w_unused_rlast;

   // Each ready/valid register is only ever set in its own state, so the
   // handshakes below are implicitly qualified by state.
   assign w_cmd_fire     = cmd_valid & r_cmd_ready;
   assign w_aw_fire      = r_awvalid & axi_awready;
   assign w_w_fire       = r_wvalid & axi_wready;
   assign w_wr_done      = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);
   assign w_b_fire       = r_bready & axi_bvalid;
   assign w_ar_fire      = r_arvalid & axi_arready;
   assign w_r_fire       = r_rready & axi_rvalid;
   assign w_rsp_fire     = r_rsp_valid & rsp_ready;
   assign w_unused_rlast = axi_rlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_cmd_fire) w_state_nxt = cmd_write ? ST_WR_REQ : ST_RD_REQ;
         ST_WR_REQ:  if (w_wr_done)  w_state_nxt = ST_WR_RESP;
         ST_WR_RESP: if (w_b_fire)   w_state_nxt = ST_RSP;
         ST_RD_REQ:  if (w_ar_fire)  w_state_nxt = ST_RD_DATA;
         ST_RD_DATA: if (w_r_fire)   w_state_nxt = ST_RSP;
         ST_RSP:     if (w_rsp_fire) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_awaddr    <= '0;
         r_wvalid    <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_wlast     <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_araddr    <= '0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= RESP_OKAY;
      end else begin
         // cmd_ready rises one cycle after the FSM lands in IDLE
         if (w_cmd_fire) begin
            r_cmd_ready <= 1'b0;
         end else if (r_state == ST_IDLE) begin
            r_cmd_ready <= 1'b1;
         end

         if (w_cmd_fire) begin
            if (cmd_write) begin
               r_awvalid <= 1'b1;
               r_awaddr  <= cmd_addr;
               r_wvalid  <= 1'b1;
               r_wdata   <= cmd_wdata;
               r_wstrb   <= cmd_wstrb;
               r_wlast   <= 1'b1;
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
            end else begin
               r_arvalid <= 1'b1;
               r_araddr  <= cmd_addr;
            end
         end

         if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
         end
         if (w_w_fire) begin
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_w_done  <= 1'b1;
         end
         if ((r_state == ST_WR_REQ) && w_wr_done) begin
            r_bready <= 1'b1;
         end
         if (w_b_fire) begin
            r_bready    <= 1'b0;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= axi_bresp;
         end

         if (w_ar_fire) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
         end
         if (w_r_fire) begin
            r_rready    <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= axi_rdata;
            r_rsp_resp  <= axi_rresp;
         end

         if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
         end else if (r_state == ST_RSP) begin
            r_rsp_valid <= 1'b1;
         end
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_write   = r_rsp_write;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;
   assign axi_awvalid = r_awvalid;
   assign axi_awaddr  = r_awaddr;
   assign axi_wvalid  = r_wvalid;
   assign axi_wdata   = r_wdata;
   assign axi_wstrb   = r_wstrb;
   assign axi_wlast   = r_wlast;
   assign axi_bready  = r_bready;
   assign axi_arvalid = r_arvalid;
   assign axi_araddr  = r_araddr;
   assign axi_rready  = r_rready;

endmodule

// File: tb/tb_iris_axil_master.sv
// Bench for iris_axil_master: AXI-Lite responder model with programmable waits,
// reference memory and a response scoreboard.
module tb_iris_axil_master;
   import iris_axil_master_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_addr  = '0;
   logic [23:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_write;
   logic        rsp_ready = 1'b0;
   logic [23:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready;
   logic [15:0] axi_awaddr, axi_araddr;
   logic [23:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0;
   logic        s_bvalid = 1'b0, s_rvalid = 1'b0, stray_b = 1'b0, stray_r = 1'b0;
   logic        axi_bvalid, axi_rvalid;
   logic [1:0]  axi_bresp = '0, axi_rresp = '0;
   logic [23:0] axi_rdata = '0;
   logic        axi_rlast = 1'b1;

   always #5 clk = ~clk;

   assign axi_bvalid = s_bvalid | stray_b;
   assign axi_rvalid = s_rvalid | stray_r;

   iris_axil_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
      .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wlast(axi_wlast), .axi_wready(axi_wready),
      .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
      .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
      .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast), .axi_rready(axi_rready)
   );

   logic [94:0] outs;
   assign outs = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
                  axi_bready, axi_arvalid, axi_araddr, axi_rready};

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- responder model ----------------
   int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   int awdly, wdly, ardly, bdly, rdly;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
   int wlast_err = 0, stray_ack = 0, busy_rdy_err = 0;
   logic aw_p, w_p, ar_p, b_p, r_p, got_aw, got_w, got_ar, b_busy, r_busy;
   logic seen_w_only = 1'b0, busy = 1'b0;
   logic [15:0] s_waddr, s_raddr;
   logic [23:0] s_wdata, cur;
   logic [3:0]  s_wstrb;
   logic [23:0] mem [logic [15:0]];

   always @(negedge clk) begin
      if (!rst_n) begin
         axi_awready = 0; axi_wready = 0; axi_arready = 0; s_bvalid = 0; s_rvalid = 0;
         aw_p = 0; w_p = 0; ar_p = 0; b_p = 0; r_p = 0;
         got_aw = 0; got_w = 0; got_ar = 0; b_busy = 0; r_busy = 0;
         awdly = 0; wdly = 0; ardly = 0; bdly = 0; rdly = 0;
      end else begin
         // retire handshakes that completed on the previous rising edge
         if (aw_p) begin axi_awready = 0; got_aw = 1; end
         if (w_p)  begin axi_wready = 0;  got_w = 1;  end
         if (ar_p) begin axi_arready = 0; got_ar = 1; end
         if (b_p)  begin s_bvalid = 0; b_cnt++; end
         if (r_p)  begin s_rvalid = 0; r_cnt++; end
         if (got_aw && got_w) begin
            cur = mem.exists(s_waddr) ? mem[s_waddr] : 24'h0;
            for (int i = 0; i < 3; i++)
               if (s_wstrb[i]) cur[8*i +: 8] = s_wdata[8*i +: 8];
            mem[s_waddr] = cur;
            got_aw = 0; got_w = 0; b_busy = 1; bdly = 0;
         end
         if (got_ar) begin got_ar = 0; r_busy = 1; rdly = 0; end
         if (b_busy) begin
            if (bdly >= b_wait) begin s_bvalid = 1; axi_bresp = RESP_OKAY; b_busy = 0; end
            else bdly++;
         end
         if (r_busy) begin
            if (rdly >= r_wait) begin
               s_rvalid = 1; r_busy = 0;
               if (s_raddr == 16'hFFFF) begin axi_rresp = RESP_SLVERR; axi_rdata = 24'h0; end
               else begin
                  axi_rresp = RESP_OKAY;
                  axi_rdata = mem.exists(s_raddr) ? mem[s_raddr] : 24'h0;
               end
            end else rdly++;
         end
         if (axi_awvalid && !axi_awready && !got_aw) begin
            if (awdly >= aw_wait) begin axi_awready = 1; s_waddr = axi_awaddr; awdly = 0; aw_cnt++; end
            else awdly++;
         end
         if (axi_wvalid && !axi_wready && !got_w) begin
            if (wdly >= w_wait) begin
               axi_wready = 1; s_wdata = axi_wdata; s_wstrb = axi_wstrb; wdly = 0; w_cnt++;
               if (!axi_wlast) wlast_err++;
            end else wdly++;
         end
         if (axi_arvalid && !axi_arready && !got_ar) begin
            if (ardly >= ar_wait) begin axi_arready = 1; s_raddr = axi_araddr; ardly = 0; ar_cnt++; end
            else ardly++;
         end
         aw_p = axi_awvalid && axi_awready;
         w_p  = axi_wvalid && axi_wready;
         ar_p = axi_arvalid && axi_arready;
         b_p  = s_bvalid && axi_bready;
         r_p  = s_rvalid && axi_rready;
      end
      if (axi_awvalid && !axi_wvalid) seen_w_only = 1;
      if ((stray_b && axi_bready) || (stray_r && axi_rready)) stray_ack++;
      if (busy && cmd_ready) busy_rdy_err++;
   end

   // ---------------- reference memory and scoreboard ----------------
   typedef struct packed { logic wr; logic [23:0] rdata; logic [1:0] resp; } exp_t;
   exp_t exp_q[$];
   logic [23:0] ref_mem [logic [15:0]];

   task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [23:0] d,
                         input logic [3:0] s, input int rsp_wait, output int lat);
      exp_t e, got;
      logic [23:0] v;
      logic unstable;
      int n;
      e.wr = wr;
      if (wr) begin
         v = ref_mem.exists(a) ? ref_mem[a] : 24'h0;
         for (int i = 0; i < 3; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
         ref_mem[a] = v;
         e.rdata = 24'h0; e.resp = RESP_OKAY;
      end else if (a == 16'hFFFF) begin
         e.rdata = 24'h0; e.resp = RESP_SLVERR;
      end else begin
         e.rdata = ref_mem.exists(a) ? ref_mem[a] : 24'h0; e.resp = RESP_OKAY;
      end
      exp_q.push_back(e);
      lat = 0;
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 0; void'(exp_q.pop_front());
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 0; busy = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
      if (!rsp_valid) begin
         chk("rsp_timeout", 0, 1);
         busy = 0; void'(exp_q.pop_front());
         return;
      end
      got = {rsp_write, rsp_rdata, rsp_resp};
      unstable = 0;
      for (int i = 0; i < rsp_wait; i++) begin
         @(negedge clk);
         if (!rsp_valid || ({rsp_write, rsp_rdata, rsp_resp} != got)) unstable = 1;
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0; busy = 0;
      e = exp_q.pop_front();
      chk("rsp_write", got.wr, e.wr);
      chk("rsp_rdata", got.rdata, e.rdata);
      chk("rsp_resp", got.resp, e.resp);
      chk("rsp_stable", unstable, 0);
      chk("rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, a0, w0, b0, r0;
      logic [15:0] rst_addr = 16'h0050;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", outs, 95'h0);
      @(negedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      chk("cmd_ready_after_reset", cmd_ready, 1);

      // zero-wait write then read-back
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      do_cmd(1'b1, 16'h0010, 24'h123456, 4'b0111, 0, lat);
      chk("wr_latency", lat, 4);
      chk("wr_aw_count", aw_cnt - a0, 1);
      chk("wr_w_count", w_cnt - w0, 1);
      chk("wr_b_count", b_cnt - b0, 1);
      a0 = ar_cnt; r0 = r_cnt;
      do_cmd(1'b0, 16'h0010, 24'h0, 4'h0, 0, lat);
      chk("rd_latency", lat, 4);
      chk("rd_ar_count", ar_cnt - a0, 1);
      chk("rd_r_count", r_cnt - r0, 1);

      // W accepted three cycles before AW; bit3 of strobe passed through
      aw_wait = 3; seen_w_only = 0;
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      do_cmd(1'b1, 16'h0020, 24'hABCDEF, 4'b1011, 0, lat);
      aw_wait = 0;
      chk("split_latency", lat, 7);
      chk("split_w_dropped_aw_held", seen_w_only, 1);
      chk("split_aw_count", aw_cnt - a0, 1);
      chk("split_w_count", w_cnt - w0, 1);
      chk("split_b_count", b_cnt - b0, 1);
      chk("wstrb_passthrough", s_wstrb, 4'b1011);
      do_cmd(1'b0, 16'h0020, 24'h0, 4'h0, 0, lat);

      // slow B/R and a consumer holding rsp_ready low
      busy_rdy_err = 0;
      b_wait = 5;
      do_cmd(1'b1, 16'h0030, 24'h0F0F0F, 4'b1111, 3, lat);
      b_wait = 0;
      chk("slow_b_latency", lat, 9);
      r_wait = 5;
      do_cmd(1'b0, 16'h0030, 24'h0, 4'h0, 3, lat);
      r_wait = 0;
      chk("slow_r_latency", lat, 9);
      chk("cmd_ready_low_while_busy", busy_rdy_err, 0);

      // error response, no retry
      a0 = ar_cnt;
      do_cmd(1'b0, 16'hFFFF, 24'h0, 4'h0, 0, lat);
      repeat (5) @(posedge clk);
      #1;
      chk("err_no_retry", ar_cnt - a0, 1);

      // stray B/R while idle must not be acknowledged
      stray_ack = 0; stray_b = 1; stray_r = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("stray_readies", {axi_bready, axi_rready}, 2'b00);
      stray_b = 0; stray_r = 0;
      chk("stray_ack_count", stray_ack, 0);

      // reset while in WR_REQ
      aw_wait = 20; w_wait = 20;
      cmd_valid = 1; cmd_write = 1; cmd_addr = rst_addr; cmd_wdata = 24'hDEAD00; cmd_wstrb = 4'hF;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 0;
      @(posedge clk); #1;
      chk("in_wr_req", {axi_awvalid, axi_wvalid}, 2'b11);
      #2 rst_n = 0;
      #1 chk("async_reset_outputs", outs, 95'h0);
      @(negedge clk); #1;
      rst_n = 1; aw_wait = 0; w_wait = 0;
      @(posedge clk); #1;
      do_cmd(1'b1, 16'h0040, 24'h777777, 4'b0111, 0, lat);
      chk("post_reset_wr_latency", lat, 4);
      do_cmd(1'b0, 16'h0040, 24'h0, 4'h0, 0, lat);
      chk("post_reset_rd_latency", lat, 4);

      chk("wlast_with_wvalid", wlast_err, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
